// File: rtl/fd_pipe_reg_pkg.sv
// pipe_pkg: shared encodings for the IF/ID pipeline register.
package pipe_pkg;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OP   = 5'b00000;
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        HALT_SEEN = 2'b01,
        HALTED    = 2'b10
    } state_t;
endpackage

// File: rtl/fd_pipe_reg_dff_en.sv
// dff_en: enabled register with a synchronous reset value.
module dff_en #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: IF/ID register with flush, stall and HALT tracking.
// Optional stall/flush counters when FD_PERF_CNT_EN is defined.
module fd_pipe_reg #(
    parameter int IW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr_in,
    input  logic [AW-1:0] pc2_in,
    input  logic          fd_nop,
    input  logic          stall,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] pc2_out,
    output logic          valid_out,
    output logic          halt_fetch,
    output logic          halted
`ifdef FD_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt
`endif
);
    import pipe_pkg::*;
    state_t state, state_n;
    logic load, bubble;
    assign load = fd_nop | ~stall;
    // once a HALT is held, everything behind it is wrong-path and gets bubbled
    assign bubble = fd_nop | (state != RUN);
    dff_en #(.W(IW), .RST_VAL(IW'(NOP_INSTR))) u_instr (
        .clk(clk), .rst(rst), .en(load),
        .d(bubble ? IW'(NOP_INSTR) : instr_in), .q(instr_out)
    );
    dff_en #(.W(AW), .RST_VAL('0)) u_pc2 (
        .clk(clk), .rst(rst), .en(load), .d(pc2_in), .q(pc2_out)
    );
    dff_en #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .rst(rst), .en(load), .d(~bubble), .q(valid_out)
    );
    always_ff @(posedge clk)
        if (rst) state <= RUN;
        else state <= state_n;
    always_comb
        state_n = fd_nop ? (state == HALTED ? HALTED : RUN) :
                  stall  ? state :
                  state == RUN ? (instr_in[IW-1:IW-5] == HALT_OP ? HALT_SEEN : RUN) :
                  HALTED;
    always_comb begin
        halt_fetch = state != RUN;
        halted     = state == HALTED;
    end
`ifdef FD_PERF_CNT_EN
    always_ff @(posedge clk)
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fd_nop && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            if (stall && !fd_nop && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
`endif
endmodule

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
- IF/ID pipeline register that receives the hazard unit's control outputs (FD_NOP flush, stall) and applies them to the instruction stream.
- Latches fetched instruction and PC+2 from fetch, and presents them to decode.
- Holds its contents on stall and inserts a NOP bubble on flush.
- Tracks HALT through a small FSM so fetch freezes once a HALT is captured, and releases again if that HALT is squashed.

Parameters:
- IW, 16, instruction width in bits
- AW, 16, PC width in bits
- NOP_INSTR, 16'h0800, encoding injected as a bubble (opcode 5'b00001)
- HALT_OP, 5'b00000, opcode in instr[15:11] identifying HALT

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- instr_in  input  IW  instruction from fetch
- pc2_in  input  AW  PC+2 from fetch
- fd_nop  input  1  flush request from hazard unit (branch/jump taken)
- stall  input  1  hold request from hazard unit
- instr_out  output  IW  registered instruction to decode
- pc2_out  output  AW  registered PC+2 to decode
- valid_out  output  1  instr_out is a real, non-squashed instruction
- halt_fetch  output  1  freeze PC/fetch; HALT captured
- halted  output  1  HALT has been held for one full cycle (to writeback/dump logic)

Behaviour:
- All state updates occur on posedge clk.
- Priority of events: rst > fd_nop > stall > normal load.
- Reset values: instr_out=NOP_INSTR, pc2_out=0, valid_out=0, halt_fetch=0, halted=0, FSM=RUN.
- Normal load (no rst, no fd_nop, no stall):
  - instr_out<=instr_in, pc2_out<=pc2_in, valid_out<=1.
  - Latency is 1 cycle.
  - Exception: in HALT_SEEN or HALTED, load NOP_INSTR with valid_out<=0.
- Stall (stall=1, fd_nop=0): all outputs and FSM state hold. Repeated stalls hold indefinitely.
- Flush (fd_nop=1): overrides stall.
  - instr_out<=NOP_INSTR, valid_out<=0, pc2_out<=pc2_in.
  - FSM returns to RUN, because a captured HALT lies on the wrong path.
- FSM states RUN, HALT_SEEN, HALTED:
  - RUN -> HALT_SEEN on a normal load with instr_in[15:11]==HALT_OP. That HALT is latched with valid_out=1.
  - HALT_SEEN -> HALTED on the next non-stall, non-flush cycle.
  - HALT_SEEN -> RUN on fd_nop.
  - HALTED is sticky until rst. fd_nop in HALTED still bubbles instr_out but does not leave HALTED.
  - Stall holds the current state.
- Outputs per state:
  - halt_fetch = 1 in HALT_SEEN and HALTED (Moore output, registered).
  - halted = 1 only in HALTED.
- A HALT arriving during a stall cycle is not captured; it is captured when the load occurs.
- rst asserted mid-operation (any state, stalled or not) returns every output to its reset value on the next edge.
- No combinational path from any input to any output.

Optional Feature:
- Macro: FD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each counter increments by 1 on every cycle its condition is true. A cycle with both stall and fd_nop counts only as a flush.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Both clear on rst.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (pipe_pkg):
  - NOP_INSTR encoding
  - HALT_OP
  - FSM state encoding: RUN=2'b00, HALT_SEEN=2'b01, HALTED=2'b10
- Sub-module: dff_en, an enabled register with synchronous reset value, instantiated for the instr, pc2 and valid fields.
- FSM and counters stay inline.

Test Plan:
- Reset then load: rst 2 cycles, then instr_in=16'hC123, pc2_in=16'h0002 -> next edge instr_out=16'hC123, pc2_out=16'h0002, valid_out=1.
- Stall hold: load 16'h4444, then stall=1 for 3 cycles with instr_in=16'h5555 -> instr_out stays 16'h4444, valid_out=1, throughout.
- Flush beats stall: stall=1 and fd_nop=1 together -> instr_out=16'h0800, valid_out=0. With FD_PERF_CNT_EN defined, flush_cnt +1 and stall_cnt unchanged.
- HALT squash: load 16'h0000 -> halt_fetch=1, then fd_nop next cycle -> state RUN, halt_fetch=0, instr_out=16'h0800.
- HALT commit: load 16'h0000, one clean cycle -> halted=1, subsequent instr_in=16'hC123 produces instr_out=16'h0800, valid_out=0. Then rst -> all outputs at reset values.
- Counter saturation (FD_PERF_CNT_EN): hold stall for 65540 cycles -> stall_cnt=16'hFFFF, no wrap.
